ipv4_hdr_csum_insert: RTL



---
 rtl/ipv4_hdr_pkg.sv | 28 ++
 rtl/ipv4_csum_acc.sv | 52 +++++
 rtl/ipv4_hdr_csum_insert.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ipv4_hdr_pkg.sv
// rtl/ipv4_hdr_pkg.sv - shared types, constants and checksum fold for the IPv4 header checksum inserter
//
// Purpose: FSM state encoding, fixed header field positions and the
// ones'-complement end-around-carry fold used by the accumulator.
// Ports: none (package).
package ipv4_hdr_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FOLD = 2'd1,
    S_SEND = 2'd2
  } state_e;

  // Header word holding the checksum in its low 16 bits.
  localparam int          CHKSUM_WORD_IDX = 2;
  localparam logic [3:0]  IPV4_VERSION    = 4'd4;

  // Two end-around-carry folds are enough: the accumulator never exceeds
  // 21 bits, so the first fold leaves at most a single carry into bit 16.
  function automatic logic [15:0] ones_fold(input logic [31:0] acc);
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
    return s2[15:0];
  endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// rtl/ipv4_csum_acc.sv - ones'-complement checksum accumulator with fold output
//
// Purpose: sums the two 16-bit halves of each accepted header word, with the
// low half optionally forced to zero (checksum field), and presents the
// 16-bit folded sum of everything accumulated so far.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   clr           clear the accumulator (takes priority over add)
//   add_en        add hi + (lo_mask ? 0 : lo) this cycle
//   hi, lo        upper / lower halves of the header word
//   lo_mask       treat lo as zero
//   fold_sum      folded 16-bit ones'-complement sum of the accumulator
module ipv4_csum_acc
  import ipv4_hdr_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        add_en,
  input  logic [15:0] hi,
  input  logic [15:0] lo,
  input  logic        lo_mask,
  output logic [15:0] fold_sum
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [15:0]      lo_eff;

  always_comb begin
    lo_eff = lo_mask ? 16'd0 : lo;
    acc_d  = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + ACC_W'(hi) + ACC_W'(lo_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign fold_sum = ones_fold(32'(acc_q));

endmodule

// File: rtl/ipv4_hdr_csum_insert.sv
// rtl/ipv4_hdr_csum_insert.sv - buffers one IPv4 header, computes and inserts its checksum
//
// Purpose: loads HDR_WORDS header words, folds the running sum in one cycle,
// writes the checksum into word 2 bits [15:0] and replays the header.
// Optional build macro IPV4_HDR_CHECK_EN: checks version/IHL of word 0 and
// drops bad headers, pulsing hdr_drop instead of sending.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_valid, in_ready, in_data    header word input stream
//   out_valid, out_ready,
//   out_data, out_last             header word output stream
//   chksum                         checksum of the last completed header
//   hdr_drop (IPV4_HDR_CHECK_EN)   one-cycle pulse when a header is dropped
module ipv4_hdr_csum_insert
  import ipv4_hdr_pkg::*;
#(
  parameter int HDR_WORDS = 5,
  parameter int ACC_W     = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] chksum
`ifdef IPV4_HDR_CHECK_EN
  ,
  output logic        hdr_drop
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(HDR_WORDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] chksum_q, chksum_d;
  logic [31:0] hdr_buf_q [HDR_WORDS];
  logic [31:0] hdr_buf_d [HDR_WORDS];
  logic [31:0] cur_word;

  logic        acc_clr;
  logic        acc_add;
  logic        lo_mask;
  logic [15:0] fold_sum;

`ifdef IPV4_HDR_CHECK_EN
  logic        drop_q, drop_d;
`endif

  ipv4_csum_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clr      (acc_clr),
    .add_en   (acc_add),
    .hi       (in_data[31:16]),
    .lo       (in_data[15:0]),
    .lo_mask  (lo_mask),
    .fold_sum (fold_sum)
  );

  // Word currently addressed by the counter; a loop avoids an index whose
  // width does not match the buffer depth.
  always_comb begin
    cur_word = 32'd0;
    for (int i = 0; i < HDR_WORDS; i++) begin
      if (cnt_q == 4'(i)) begin
        cur_word = hdr_buf_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chksum_d  = chksum_q;
    hdr_buf_d = hdr_buf_q;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    lo_mask   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 32'd0;
    out_last  = 1'b0;
`ifdef IPV4_HDR_CHECK_EN
    drop_d    = drop_q;
    hdr_drop  = 1'b0;
`endif

    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int i = 0; i < HDR_WORDS; i++) begin
            if (cnt_q == 4'(i)) begin
              hdr_buf_d[i] = in_data;
            end
          end
          acc_add = 1'b1;
          // The stale checksum field must not contribute to the sum.
          lo_mask = (cnt_q == 4'(CHKSUM_WORD_IDX));
`ifdef IPV4_HDR_CHECK_EN
          if (cnt_q == 4'd0) begin
            drop_d = (in_data[31:28] != IPV4_VERSION) ||
                     (in_data[27:24] != 4'(HDR_WORDS));
          end
`endif
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_IDX) begin
            state_d = S_FOLD;
          end
        end
      end

      S_FOLD: begin
        acc_clr = 1'b1;
        cnt_d   = 4'd0;
`ifdef IPV4_HDR_CHECK_EN
        if (drop_q) begin
          hdr_drop = 1'b1;
          drop_d   = 1'b0;
          state_d  = S_LOAD;
        end else
`endif
        begin
          chksum_d = ~fold_sum;
          hdr_buf_d[CHKSUM_WORD_IDX][15:0] = ~fold_sum;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        out_valid = 1'b1;
        out_data  = cur_word;
        out_last  = (cnt_q == LAST_IDX);
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = 4'd0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = S_LOAD;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD;
      cnt_q    <= 4'd0;
      chksum_q <= 16'd0;
      for (int i = 0; i < HDR_WORDS; i++) begin
        hdr_buf_q[i] <= 32'd0;
      end
`ifdef IPV4_HDR_CHECK_EN
      drop_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      chksum_q  <= chksum_d;
      hdr_buf_q <= hdr_buf_d;
`ifdef IPV4_HDR_CHECK_EN
      drop_q    <= drop_d;
`endif
    end
  end

  assign chksum = chksum_q;

endmodule
